capture_ring_writer: RTL and testbench

//  Pre/post-trigger waveform capture engine for the three-phase analyzer.

---
 rtl/capture_ring_writer_if.sv | 45 ++++
 rtl/capture_ring_writer.sv | 183 ++++++++++++++++++
 tb/tb_capture_ring_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_ring_writer_if.sv
// Sample-stream and RAM write-port bundle for the capture ring writer.
// The slave modport is the capture engine: it sinks the sample stream and
// drives the Avalon-style RAM write port. The master modport is the other side.
interface capture_ring_writer_if #(
  parameter int ADDR_W = 15
) ();

  // Sample stream (valid/ready)
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;

  // RAM write port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output mem_address,
    output mem_chipselect,
    output mem_write,
    output mem_byteenable,
    output mem_writedata,
    output mem_clken
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  mem_address,
    input  mem_chipselect,
    input  mem_write,
    input  mem_byteenable,
    input  mem_writedata,
    input  mem_clken
  );

endinterface

// File: rtl/capture_ring_writer.sv
// Pre/post-trigger capture engine. Writes accepted sample words into a ring
// region of the on-chip RAM, stops L-P words after a qualified trigger and
// reports the address of the oldest word so software reads a time-ordered record.
// ADDR_W must match the ADDR_W of the connected interface instance.
module capture_ring_writer #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 25000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W-1:0]     cfg_length,
  input  logic [ADDR_W-1:0]     cfg_pretrig,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trigger,
  capture_ring_writer_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [ADDR_W-1:0]     oldest_addr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Control state
  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [ADDR_W-1:0] len_q,      len_d;
  logic [ADDR_W-1:0] pre_q,      pre_d;
  logic [ADDR_W-1:0] wptr_q,     wptr_d;
  logic [ADDR_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [ADDR_W-1:0] post_rem_q, post_rem_d;
  logic              cfg_err_q,  cfg_err_d;
  logic              done_q,     done_d;
  logic [ADDR_W-1:0] oldest_q,   oldest_d;

  // Registered RAM write port
  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              capturing;
  logic              s_ready;
  logic              accept;
  logic [ADDR_W-1:0] wptr_next;
  logic [ADDR_W-1:0] wr_addr;
  logic              start_bad;

  // Handshake, ring pointer advance and start validation
  always_comb begin
    capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    // abort withdraws ready in the same cycle so nothing new enters the pipe
    s_ready   = capturing && !abort;
    accept    = bus.s_valid && s_ready;
    wptr_next = (wptr_q == len_q - ONE_A) ? '0 : wptr_q + ONE_A;
    wr_addr   = base_q + wptr_q;
    // End-of-region check is done one bit wider so base+L cannot wrap
    start_bad = (cfg_length == '0) || (cfg_pretrig >= cfg_length) ||
                (({1'b0, cfg_base} + {1'b0, cfg_length}) > DEPTH_W);
  end

  // Next-state logic; priority abort > start > trigger > data
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    pre_d      = pre_q;
    wptr_d     = wptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_rem_d = post_rem_q;
    cfg_err_d  = cfg_err_q;
    done_d     = 1'b0;
    oldest_d   = oldest_q;
    wr_d       = accept;
    addr_d     = accept ? wr_addr    : addr_q;
    wdata_d    = accept ? bus.s_data : wdata_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              base_d    = cfg_base;
              len_d     = cfg_length;
              pre_d     = cfg_pretrig;
              wptr_d    = '0;
              pre_cnt_d = '0;
              cfg_err_d = 1'b0;
              state_d   = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (accept) begin
            wptr_d = wptr_next;
            if (pre_cnt_q != pre_q) pre_cnt_d = pre_cnt_q + ONE_A;
          end
          // Qualification uses the count before this cycle's word, so a word
          // arriving with the trigger still belongs to the pre-trigger part
          if (trigger && (pre_cnt_q == pre_q)) begin
            post_rem_d = len_q - pre_q;
            state_d    = ST_POST;
          end
        end
        ST_POST: begin
          if (accept) begin
            wptr_d     = wptr_next;
            post_rem_d = post_rem_q - ONE_A;
            if (post_rem_q == ONE_A) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              oldest_d = base_q + wptr_next;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and write-port registers
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      pre_q      <= '0;
      wptr_q     <= '0;
      pre_cnt_q  <= '0;
      post_rem_q <= '0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      oldest_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      pre_q      <= pre_d;
      wptr_q     <= wptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_rem_q <= post_rem_d;
      cfg_err_q  <= cfg_err_d;
      done_q     <= done_d;
      oldest_q   <= oldest_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Outputs
  always_comb begin
    bus.s_ready        = s_ready;
    bus.mem_address    = addr_q;
    bus.mem_chipselect = wr_q;
    bus.mem_write      = wr_q;
    bus.mem_byteenable = 4'hF;
    bus.mem_writedata  = wdata_q;
    bus.mem_clken      = 1'b1;
    busy               = capturing;
    done               = done_q;
    cfg_err            = cfg_err_q;
    oldest_addr        = oldest_q;
  end

endmodule

// File: tb/tb_capture_ring_writer.sv
// Directed bench for capture_ring_writer: a per-cycle vector table for the
// continuous-stream ring case plus hand-written sequences for fill, rejects,
// abort and asynchronous reset. A small RAM model records the writes.
`timescale 1ns/1ps
module tb_capture_ring_writer;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] cfg_base, cfg_length, cfg_pretrig;
  logic              start, abort, trigger;
  logic              busy, done, cfg_err;
  logic [ADDR_W-1:0] oldest_addr;

  int checks   = 0;
  int failures = 0;

  capture_ring_writer_if #(.ADDR_W(ADDR_W)) bus ();

  capture_ring_writer #(.ADDR_W(ADDR_W), .DEPTH(25000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_base   (cfg_base),
    .cfg_length (cfg_length),
    .cfg_pretrig(cfg_pretrig),
    .start      (start),
    .abort      (abort),
    .trigger    (trigger),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .oldest_addr(oldest_addr)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [31:0] ram [0:24999];
  int          wr_count = 0;
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_write) begin
      ram[bus.mem_address] <= bus.mem_writedata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic              st;
    logic              tr;
    logic              vl;
    logic [31:0]       data;
    logic              exp_ready;
    logic              exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_busy;
    logic              exp_done;
  } vec_t;

  vec_t tv [10];

  function automatic vec_t mk(input logic st, input logic tr, input logic vl,
                              input logic [31:0] d, input logic rdy, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.tr = tr; v.vl = vl; v.data = d;
    v.exp_ready = rdy; v.exp_wr = wr; v.exp_addr = a; v.exp_busy = bsy; v.exp_done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int b, input int l, input int p);
    cfg_base    = ADDR_W'(b);
    cfg_length  = ADDR_W'(l);
    cfg_pretrig = ADDR_W'(p);
  endtask

  // One clock cycle: apply inputs, sample s_ready before the edge, return #1 after it
  task automatic cyc(input logic st, input logic tr, input logic vl,
                     input logic [31:0] d, input logic ab, output logic rdy);
    start       = st;
    trigger     = tr;
    bus.s_valid = vl;
    bus.s_data  = d;
    abort       = ab;
    #1;
    rdy = bus.s_ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Registered write-port check after an edge
  task automatic check_wr(input string tag, input logic exp_wr,
                          input int exp_addr, input logic [31:0] exp_data);
    check({tag, " mem_write"}, 32'(bus.mem_write), 32'(exp_wr));
    check({tag, " mem_chipselect"}, 32'(bus.mem_chipselect), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, " mem_address"}, 32'(bus.mem_address), 32'(exp_addr));
      check({tag, " mem_writedata"}, bus.mem_writedata, exp_data);
    end
  endtask

  logic rdy;
  int   cnt_before;

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    trigger     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    set_cfg(0, 0, 0);
    #2;

    // ---------------- reset state ----------------
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst cfg_err", 32'(cfg_err), 32'd0);
    check("rst oldest_addr", 32'(oldest_addr), 32'd0);
    check("rst s_ready", 32'(bus.s_ready), 32'd0);
    check("rst mem_write", 32'(bus.mem_write), 32'd0);
    check("rst mem_chipselect", 32'(bus.mem_chipselect), 32'd0);
    check("rst mem_address", 32'(bus.mem_address), 32'd0);
    check("rst mem_writedata", bus.mem_writedata, 32'd0);
    check("rst mem_byteenable", 32'(bus.mem_byteenable), 32'hF);
    check("rst mem_clken", 32'(bus.mem_clken), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- P=0 fill from base 100 ----------------
    set_cfg(100, 8, 0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, rdy);
    check("t1 start busy", 32'(busy), 32'd1);
    check("t1 start cfg_err", 32'(cfg_err), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, rdy);     // trigger qualifies, no word
    check("t1 trig ready", 32'(rdy), 32'd1);
    check_wr("t1 trig", 1'b0, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, rdy);
      check($sformatf("t1 w%0d ready", i), 32'(rdy), 32'd1);
      check_wr($sformatf("t1 w%0d", i), 1'b1, 100 + i, 32'hD000_0000 + 32'(i));
      check($sformatf("t1 w%0d done", i), 32'(done), 32'(i == 7));
      check($sformatf("t1 w%0d busy", i), 32'(busy), 32'(i != 7));
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, rdy);
    check("t1 done pulse ends", 32'(done), 32'd0);
    check("t1 no extra write", 32'(bus.mem_write), 32'd0);
    check("t1 oldest_addr", 32'(oldest_addr), 32'd100);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1 ram[%0d]", 100 + i), ram[100 + i], 32'hD000_0000 + 32'(i));

    // ---------------- P=2, trigger held from the start ----------------
    set_cfg(0, 4, 2);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, rdy);
    check("t2 start busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'd1, 1'b0, rdy);
    check_wr("t2 w1", 1'b1, 0, 32'd1);
    check("t2 w1 done", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'd2, 1'b0, rdy);
    check_wr("t2 w2", 1'b1, 1, 32'd2);
    check("t2 w2 done", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, rdy);     // pre-fill complete: trigger qualifies
    check("t2 gap busy", 32'(busy), 32'd1);
    check("t2 gap done", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'd3, 1'b0, rdy);
    check_wr("t2 w3", 1'b1, 2, 32'd3);
    check("t2 w3 done", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'd4, 1'b0, rdy);
    check_wr("t2 w4", 1'b1, 3, 32'd4);
    check("t2 w4 done", 32'(done), 32'd1);
    check("t2 w4 busy", 32'(busy), 32'd0);
    cnt_before = wr_count;
    for (int i = 5; i <= 9; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'(i), 1'b0, rdy);
      check($sformatf("t2 w%0d ready", i), 32'(rdy), 32'd0);
      check($sformatf("t2 w%0d mem_write", i), 32'(bus.mem_write), 32'd0);
    end
    check("t2 write count", 32'(wr_count - cnt_before), 32'd1);  // only w4's write lands
    for (int i = 0; i < 4; i++)
      check($sformatf("t2 ram[%0d]", i), ram[i], 32'(i + 1));
    check("t2 oldest_addr", 32'(oldest_addr), 32'd0);

    // ---------------- P=2, trigger with word 6 (table, start from DONE) ----------------
    set_cfg(0, 4, 2);
    tv[0] = mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 15'd0, 1'b1, 1'b0);
    tv[1] = mk(1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 15'd0, 1'b1, 1'b0);
    tv[2] = mk(1'b0, 1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 15'd1, 1'b1, 1'b0);
    tv[3] = mk(1'b0, 1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 15'd2, 1'b1, 1'b0);
    tv[4] = mk(1'b0, 1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 15'd3, 1'b1, 1'b0);
    tv[5] = mk(1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 15'd0, 1'b1, 1'b0);
    tv[6] = mk(1'b0, 1'b1, 1'b1, 32'd6, 1'b1, 1'b1, 15'd1, 1'b1, 1'b0);
    tv[7] = mk(1'b0, 1'b0, 1'b1, 32'd7, 1'b1, 1'b1, 15'd2, 1'b1, 1'b0);
    tv[8] = mk(1'b0, 1'b0, 1'b1, 32'd8, 1'b1, 1'b1, 15'd3, 1'b0, 1'b1);
    tv[9] = mk(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].st, tv[i].tr, tv[i].vl, tv[i].data, 1'b0, rdy);
      check($sformatf("t3 v%0d ready", i), 32'(rdy), 32'(tv[i].exp_ready));
      check_wr($sformatf("t3 v%0d", i), tv[i].exp_wr, int'(tv[i].exp_addr), tv[i].data);
      check($sformatf("t3 v%0d busy", i), 32'(busy), 32'(tv[i].exp_busy));
      check($sformatf("t3 v%0d done", i), 32'(done), 32'(tv[i].exp_done));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t3 ram[%0d]", i), ram[i], 32'(i + 5));
    check("t3 oldest_addr", 32'(oldest_addr), 32'd0);

    // ---------------- config rejects ----------------
    set_cfg(0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, rdy);
    check("rej L0 cfg_err", 32'(cfg_err), 32'd1);
    check("rej L0 busy", 32'(busy), 32'd0);
    check("rej L0 mem_write", 32'(bus.mem_write), 32'd0);
    set_cfg(0, 5, 5);
    cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, rdy);
    check("rej P=L cfg_err", 32'(cfg_err), 32'd1);
    check("rej P=L busy", 32'(busy), 32'd0);
    check("rej P=L mem_write", 32'(bus.mem_write), 32'd0);
    set_cfg(24998, 3, 0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, rdy);
    check("rej end cfg_err", 32'(cfg_err), 32'd1);
    check("rej end busy", 32'(busy), 32'd0);
    check("rej end mem_write", 32'(bus.mem_write), 32'd0);
    check("rej end done", 32'(done), 32'd0);
    // Region ending exactly at DEPTH is legal
    set_cfg(24997, 3, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
    check("acc end cfg_err", 32'(cfg_err), 32'd0);
    check("acc end busy", 32'(busy), 32'd1);

    // ---------------- abort during POST ----------------
    cyc(1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, rdy);
    check_wr("ab wa", 1'b1, 24997, 32'hAA);
    cyc(1'b0, 1'b1, 1'b1, 32'hBB, 1'b0, rdy);
    check_wr("ab wb", 1'b1, 24998, 32'hBB);
    cyc(1'b0, 1'b0, 1'b1, 32'hCC, 1'b0, rdy);
    check_wr("ab wc", 1'b1, 24999, 32'hCC);
    check("ab wc busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 32'hDD, 1'b1, rdy);
    check("ab ready", 32'(rdy), 32'd0);
    check("ab mem_write", 32'(bus.mem_write), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'hEE, 1'b0, rdy);
    check("ab idle ready", 32'(rdy), 32'd0);
    check("ab idle mem_write", 32'(bus.mem_write), 32'd0);
    check("ab idle done", 32'(done), 32'd0);
    check("ab oldest_addr", 32'(oldest_addr), 32'd0);
    check("ab cfg_err", 32'(cfg_err), 32'd0);
    check("ab ram[24999]", ram[24999], 32'hCC);

    // ---------------- async reset mid-ARMED ----------------
    set_cfg(10, 4, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
    cyc(1'b0, 1'b0, 1'b1, 32'h11, 1'b0, rdy);
    check("rs pre mem_write", 32'(bus.mem_write), 32'd1);
    bus.s_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("rs mem_write", 32'(bus.mem_write), 32'd0);
    check("rs mem_chipselect", 32'(bus.mem_chipselect), 32'd0);
    check("rs busy", 32'(busy), 32'd0);
    check("rs s_ready", 32'(bus.s_ready), 32'd0);
    check("rs done", 32'(done), 32'd0);
    check("rs cfg_err", 32'(cfg_err), 32'd0);
    check("rs oldest_addr", 32'(oldest_addr), 32'd0);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
    check("rs2 busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 32'h51, 1'b0, rdy);
    check_wr("rs2 w1", 1'b1, 10, 32'h51);
    cyc(1'b0, 1'b1, 1'b1, 32'h52, 1'b0, rdy);
    check_wr("rs2 w2", 1'b1, 11, 32'h52);
    cyc(1'b0, 1'b0, 1'b1, 32'h53, 1'b0, rdy);
    check_wr("rs2 w3", 1'b1, 12, 32'h53);
    cyc(1'b0, 1'b0, 1'b1, 32'h54, 1'b0, rdy);
    check_wr("rs2 w4", 1'b1, 13, 32'h54);
    check("rs2 w4 done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, rdy);
    check_wr("rs2 w5", 1'b1, 10, 32'h55);
    check("rs2 w5 done", 32'(done), 32'd1);
    check("rs2 oldest_addr", 32'(oldest_addr), 32'd11);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, rdy);
    check("rs2 ram[10]", ram[10], 32'h55);
    check("rs2 ram[11]", ram[11], 32'h52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
